// File: rtl/slab_interval_sequencer.sv
// slab_interval_sequencer: drives a shared, pipelined FloPoCo less_or_equal
// comparator through the five compares of a ray/AABB slab test.
// t_near = max(tx0,ty0,tz0), t_far = min(tx1,ty1,tz1), hit = t_near <= t_far.
//
// Handshakes: both ports use valid/ready. A transfer happens on a rising
// clk edge where valid && ready are both 1. in_ready is 1 only in IDLE.
// out_valid is 1 only in DONE, where hit/t_near/t_far/exc are held until
// the transfer edge. The design expects LAT >= 2: the first result of a
// pair must land after both operands of that pair were issued.
module slab_interval_sequencer #(
    parameter int WIDTH = 35,
    parameter int LAT   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   tx0,
    input  logic [WIDTH:0]   ty0,
    input  logic [WIDTH:0]   tz0,
    input  logic [WIDTH:0]   tx1,
    input  logic [WIDTH:0]   ty1,
    input  logic [WIDTH:0]   tz1,
    output logic [WIDTH:0]   cmp_a,
    output logic [WIDTH:0]   cmp_b,
    input  logic             cmp_le,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             hit,
    output logic [WIDTH:0]   t_near,
    output logic [WIDTH:0]   t_far,
    output logic             exc,
    output logic             busy,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        IDLE, ISS_A, WAIT_A, ISS_B, WAIT_B, ISS_C, WAIT_C, DONE
    } state_t;

    localparam int CW = $clog2(LAT + 1);

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt;
    logic           second;
    logic           issue_first;
    logic           accept;
    logic           in_exc;
    logic           take_first;
    logic           take_second;
    logic           in_wait;
    logic [WIDTH:0] x0_q, y0_q, z0_q, x1_q, y1_q, z1_q;
    logic [WIDTH:0] tn_q, tf_q;
    logic           hit_q, exc_q;

    // Exception field top bit set means inf (10) or NaN (11).
    assign in_exc = tx0[WIDTH] | ty0[WIDTH] | tz0[WIDTH]
                  | tx1[WIDTH] | ty1[WIDTH] | tz1[WIDTH];

    assign in_ready  = (state == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign dbg_state = state;
    assign hit       = hit_q;
    assign exc       = exc_q;
    assign t_near    = tn_q;
    assign t_far     = tf_q;

    // The counter reaches 1 in the result cycle of the first pair of a phase
    // and 0 in the result cycle of the second pair.
    assign in_wait     = (state == WAIT_A) || (state == WAIT_B) || (state == WAIT_C);
    assign take_first  = in_wait && (cnt == CW'(1));
    assign take_second = ((state == WAIT_A) || (state == WAIT_B)) && (cnt == '0);

    // Next-state and comparator operand selection; operands are zero on idle cycles.
    always_comb begin
        state_nxt   = state;
        cmp_a       = '0;
        cmp_b       = '0;
        issue_first = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = in_exc ? DONE : ISS_A;
            end
            ISS_A: begin
                if (!second) begin
                    cmp_a       = x0_q;
                    cmp_b       = y0_q;
                    issue_first = 1'b1;
                end else begin
                    cmp_a     = x1_q;
                    cmp_b     = y1_q;
                    state_nxt = WAIT_A;
                end
            end
            WAIT_A: begin
                if (cnt == '0) state_nxt = ISS_B;
            end
            ISS_B: begin
                if (!second) begin
                    cmp_a       = tn_q;
                    cmp_b       = z0_q;
                    issue_first = 1'b1;
                end else begin
                    cmp_a     = tf_q;
                    cmp_b     = z1_q;
                    state_nxt = WAIT_B;
                end
            end
            WAIT_B: begin
                if (cnt == '0) state_nxt = ISS_C;
            end
            ISS_C: begin
                cmp_a       = tn_q;
                cmp_b       = tf_q;
                issue_first = 1'b1;
                state_nxt   = WAIT_C;
            end
            WAIT_C: begin
                if (cnt == CW'(1)) state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Latency counter and issue sub-phase; reset drops any in-flight result.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            second <= 1'b0;
        end else begin
            if (issue_first)      cnt <= CW'(LAT);
            else if (cnt != '0)   cnt <= cnt - CW'(1);
            second <= ((state == ISS_A) || (state == ISS_B)) && !second;
        end
    end

    // Capture the six slab distances on the input transfer.
    always_ff @(posedge clk) begin
        if (accept) begin
            x0_q <= tx0;
            y0_q <= ty0;
            z0_q <= tz0;
            x1_q <= tx1;
            y1_q <= ty1;
            z1_q <= tz1;
        end
    end

    // Fold comparator results into the running max/min and the final hit flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            tn_q  <= '0;
            tf_q  <= '0;
            hit_q <= 1'b0;
            exc_q <= 1'b0;
        end else if (accept) begin
            exc_q <= in_exc;
            hit_q <= 1'b0;
            if (in_exc) begin
                tn_q <= '0;
                tf_q <= '0;
            end
        end else begin
            case (state)
                WAIT_A: begin
                    if (take_first)  tn_q <= cmp_le ? y0_q : x0_q;
                    if (take_second) tf_q <= cmp_le ? x1_q : y1_q;
                end
                WAIT_B: begin
                    if (take_first)  tn_q <= cmp_le ? z0_q : tn_q;
                    if (take_second) tf_q <= cmp_le ? tf_q : z1_q;
                end
                WAIT_C: begin
                    if (take_first)  hit_q <= cmp_le;
                end
                default: ;
            endcase
        end
    end

endmodule
